// File: rtl/video_stream_mux_n.sv
// N-channel video stream selector: channel switches land only on frame boundaries, output registered (1-cycle latency).
// Optional frame statistics are enabled by defining VIDEO_MUX_FRAME_STATS_EN.
module video_stream_mux_n #(
   parameter int NUM_CH  = 4,
   parameter int SEL_W   = 2,
   parameter int PIX_W   = 24,
   parameter int CFG_W   = 8,
   parameter int CFG_RST = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_frame,
   input  logic [SEL_W-1:0]        sel_req,
   input  logic [CFG_W-1:0]        cfg_in,
   output logic [CFG_W-1:0]        cfg_out,
   input  logic [NUM_CH*PIX_W-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_sop,
   input  logic [NUM_CH-1:0]       in_eop,
   output logic [PIX_W-1:0]        out_data,
   output logic                    out_valid,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic [SEL_W-1:0]        active_sel,
   output logic                    switch_pending,
   output logic                    sel_err,
   output logic                    frame_err,
   output logic [15:0]             frame_cnt,
   output logic [23:0]             last_frame_len
);

   typedef enum logic {WAIT_SOP, IN_FRAME} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] pend_sel;
   logic             beat, beat_sop, beat_eop;
   logic [PIX_W-1:0] beat_data;
   logic             fwd, fwd_err, switch_now, sel_legal;

   assign switch_pending = (pend_sel != active_sel);
   assign sel_legal      = ({1'b0, sel_req} < (SEL_W+1)'(NUM_CH));

   always_comb begin
      beat      = 1'b0;
      beat_sop  = 1'b0;
      beat_eop  = 1'b0;
      beat_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (active_sel == SEL_W'(k)) begin
            beat      = in_valid[k];
            beat_sop  = in_valid[k] & in_sop[k];
            beat_eop  = in_valid[k] & in_eop[k];
            beat_data = in_data[k*PIX_W +: PIX_W];
         end
      end
   end

   // A pending switch takes priority in WAIT_SOP and costs one idle cycle.
   always_comb begin
      state_nxt  = state;
      fwd        = 1'b0;
      fwd_err    = 1'b0;
      switch_now = 1'b0;
      case (state)
         WAIT_SOP: begin
            if (switch_pending) begin
               switch_now = 1'b1;
            end else if (beat_sop) begin
               fwd = 1'b1;
               if (!beat_eop) state_nxt = IN_FRAME;
            end
         end
         IN_FRAME: begin
            if (beat) begin
               fwd     = 1'b1;
               fwd_err = beat_sop;
               if (beat_eop) state_nxt = WAIT_SOP;
            end
         end
         default: state_nxt = WAIT_SOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_SOP;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_sel <= '0;
         pend_sel   <= '0;
         cfg_out    <= CFG_W'(CFG_RST);
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         sel_err    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         out_valid <= fwd;
         out_sop   <= fwd & beat_sop;
         out_eop   <= fwd & beat_eop;
         frame_err <= fwd_err;
         if (fwd) out_data <= beat_data;
         if (switch_now) active_sel <= pend_sel;
         sel_err <= 1'b0;
         if (start_frame) begin
            cfg_out <= cfg_in;
            if (sel_legal) pend_sel <= sel_req;
            else           sel_err  <= 1'b1;
         end
      end
   end

`ifdef VIDEO_MUX_FRAME_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [23:0] beat_cnt, beat_cnt_nxt, len_q;

   // Beat count includes the sop and eop beats and saturates rather than wrapping.
   always_comb begin
      beat_cnt_nxt = beat_cnt;
      if (fwd) begin
         if (beat_sop)                     beat_cnt_nxt = 24'd1;
         else if (beat_cnt != 24'hFFFFFF)  beat_cnt_nxt = beat_cnt + 24'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
         beat_cnt    <= '0;
         len_q       <= '0;
      end else begin
         beat_cnt <= beat_cnt_nxt;
         if (fwd && beat_eop) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            len_q       <= beat_cnt_nxt;
         end
      end
   end

   assign frame_cnt      = frame_cnt_q;
   assign last_frame_len = len_q;
`else
   assign frame_cnt      = '0;
   assign last_frame_len = '0;
`endif

endmodule

// File: tb/tb_video_stream_mux_n.sv
// Directed self-checking bench for video_stream_mux_n, built with NUM_CH = 3 so an illegal select exists.
module tb_video_stream_mux_n;

   localparam int NUM_CH = 3;
   localparam int SEL_W  = 2;
   localparam int PIX_W  = 24;
   localparam int CFG_W  = 8;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start_frame;
   logic [SEL_W-1:0]        sel_req;
   logic [CFG_W-1:0]        cfg_in;
   logic [CFG_W-1:0]        cfg_out;
   logic [NUM_CH*PIX_W-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid, in_sop, in_eop;
   logic [PIX_W-1:0]        out_data;
   logic                    out_valid, out_sop, out_eop;
   logic [SEL_W-1:0]        active_sel;
   logic                    switch_pending, sel_err, frame_err;
   logic [15:0]             frame_cnt;
   logic [23:0]             last_frame_len;

   int tests_run = 0;
   int tests_failed = 0;

   video_stream_mux_n #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .PIX_W(PIX_W), .CFG_W(CFG_W), .CFG_RST(10)) dut (
      .clk(clk), .reset(reset), .start_frame(start_frame), .sel_req(sel_req), .cfg_in(cfg_in),
      .cfg_out(cfg_out), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .active_sel(active_sel), .switch_pending(switch_pending), .sel_err(sel_err),
      .frame_err(frame_err), .frame_cnt(frame_cnt), .last_frame_len(last_frame_len)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Present one beat on channel ch (others idle) across one rising edge; outputs then show its result.
   task automatic applyStimulus(input int ch, input logic vld, input logic [PIX_W-1:0] d,
                                input logic s, input logic e);
      in_data  = '0;
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      in_data[ch*PIX_W +: PIX_W] = d;
      in_valid[ch] = vld;
      in_sop[ch]   = s;
      in_eop[ch]   = e;
      @(posedge clk);
      #1;
      start_frame = 1'b0;
      in_valid    = '0;
   endtask

   task automatic sendFrame(input string tag, input int ch, input logic [PIX_W-1:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         applyStimulus(ch, 1'b1, base + PIX_W'(i), i == 0, i == len - 1);
         checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
         checkOutput({tag, "_data"}, 32'(out_data), 32'(base + PIX_W'(i)));
         checkOutput({tag, "_sop"}, 32'(out_sop), 32'(i == 0));
         checkOutput({tag, "_eop"}, 32'(out_eop), 32'(i == len - 1));
      end
   endtask

   initial begin
      reset = 1'b1;
      start_frame = 1'b0;
      sel_req = '0;
      cfg_in = '0;
      in_data = '0;
      in_valid = '0;
      in_sop = '0;
      in_eop = '0;
      applyStimulus(0, 1'b0, 24'h0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 24'h0, 1'b0, 1'b0);
      reset = 1'b0;
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_data", 32'(out_data), 32'd0);
      checkOutput("rst_active", 32'(active_sel), 32'd0);
      checkOutput("rst_cfg", 32'(cfg_out), 32'd10);
      checkOutput("rst_pending", 32'(switch_pending), 32'd0);
      checkOutput("rst_selerr", 32'(sel_err), 32'd0);
      checkOutput("rst_frmerr", 32'(frame_err), 32'd0);

      sendFrame("f1", 0, 24'h000001, 4);
      applyStimulus(0, 1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("f1_idle_valid", 32'(out_valid), 32'd0);
      checkOutput("f1_idle_hold", 32'(out_data), 32'h4);
      checkOutput("f1_cfg", 32'(cfg_out), 32'd10);

      // Switch request mid-frame: ch0 frame must finish intact first.
      applyStimulus(0, 1'b1, 24'h10, 1'b1, 1'b0);
      start_frame = 1'b1;
      sel_req = 2'd2;
      cfg_in = 8'h33;
      applyStimulus(0, 1'b1, 24'h11, 1'b0, 1'b0);
      checkOutput("sw_cfg", 32'(cfg_out), 32'h33);
      checkOutput("sw_pending", 32'(switch_pending), 32'd1);
      checkOutput("sw_still0", 32'(active_sel), 32'd0);
      checkOutput("sw_mid_data", 32'(out_data), 32'h11);
      applyStimulus(0, 1'b1, 24'h12, 1'b0, 1'b0);
      checkOutput("sw_mid2_valid", 32'(out_valid), 32'd1);
      applyStimulus(0, 1'b1, 24'h13, 1'b0, 1'b1);
      checkOutput("sw_eop", 32'(out_eop), 32'd1);
      checkOutput("sw_eop_data", 32'(out_data), 32'h13);
      applyStimulus(2, 1'b1, 24'h20, 1'b0, 1'b0);
      checkOutput("sw_done_active", 32'(active_sel), 32'd2);
      checkOutput("sw_done_valid", 32'(out_valid), 32'd0);
      checkOutput("sw_done_pending", 32'(switch_pending), 32'd0);

      // ch2 mid-frame beats and a ch0 sop are both ignored.
      applyStimulus(2, 1'b1, 24'h21, 1'b0, 1'b0);
      checkOutput("join_drop", 32'(out_valid), 32'd0);
      applyStimulus(0, 1'b1, 24'h99, 1'b1, 1'b0);
      checkOutput("other_ch_drop", 32'(out_valid), 32'd0);
      checkOutput("drop_hold", 32'(out_data), 32'h13);
      sendFrame("f2", 2, 24'h30, 3);

      // Illegal select: sel_err for one cycle, routing unchanged.
      start_frame = 1'b1;
      sel_req = 2'd3;
      cfg_in = 8'h44;
      applyStimulus(2, 1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("bad_selerr", 32'(sel_err), 32'd1);
      checkOutput("bad_pending", 32'(switch_pending), 32'd0);
      checkOutput("bad_cfg", 32'(cfg_out), 32'h44);
      applyStimulus(2, 1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("bad_selerr_clr", 32'(sel_err), 32'd0);
      checkOutput("bad_active", 32'(active_sel), 32'd2);
      sendFrame("single", 2, 24'h40, 1);

      // Back to ch0, then a duplicate sop inside the frame.
      start_frame = 1'b1;
      sel_req = 2'd0;
      applyStimulus(0, 1'b0, 24'h0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("back_active", 32'(active_sel), 32'd0);
      applyStimulus(0, 1'b1, 24'h50, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 24'h51, 1'b0, 1'b0);
      checkOutput("dup_pre_err", 32'(frame_err), 32'd0);
      applyStimulus(0, 1'b1, 24'h52, 1'b1, 1'b0);
      checkOutput("dup_err", 32'(frame_err), 32'd1);
      checkOutput("dup_sop", 32'(out_sop), 32'd1);
      checkOutput("dup_valid", 32'(out_valid), 32'd1);
      applyStimulus(0, 1'b1, 24'h53, 1'b0, 1'b0);
      checkOutput("dup_err_clr", 32'(frame_err), 32'd0);
      checkOutput("dup_inframe", 32'(out_valid), 32'd1);
      checkOutput("dup_inframe_data", 32'(out_data), 32'h53);

      // Reset mid-frame truncates; output resumes on ch0 at the next sop only.
      reset = 1'b1;
      applyStimulus(0, 1'b1, 24'h54, 1'b0, 1'b1);
      reset = 1'b0;
      checkOutput("mrst_valid", 32'(out_valid), 32'd0);
      checkOutput("mrst_eop", 32'(out_eop), 32'd0);
      checkOutput("mrst_cfg", 32'(cfg_out), 32'd10);
      applyStimulus(0, 1'b1, 24'h62, 1'b0, 1'b0);
      checkOutput("mrst_drop", 32'(out_valid), 32'd0);

      sendFrame("s5", 0, 24'h70, 5);
`ifdef VIDEO_MUX_FRAME_STATS_EN
      checkOutput("s5_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("s5_len", 32'(last_frame_len), 32'd5);
`endif
      sendFrame("s1", 0, 24'h80, 1);
`ifdef VIDEO_MUX_FRAME_STATS_EN
      checkOutput("s1_cnt", 32'(frame_cnt), 32'd2);
      checkOutput("s1_len", 32'(last_frame_len), 32'd1);
`endif
      sendFrame("s7", 0, 24'h90, 7);
`ifdef VIDEO_MUX_FRAME_STATS_EN
      checkOutput("s7_cnt", 32'(frame_cnt), 32'd3);
      checkOutput("s7_len", 32'(last_frame_len), 32'd7);
`else
      checkOutput("nostats_cnt", 32'(frame_cnt), 32'd0);
      checkOutput("nostats_len", 32'(last_frame_len), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/video_stream_mux_n.md
Name: video_stream_mux_n

Overview:
Parametrised N-channel video stream selector feeding the framebuffer write path, for camera 0/1, HDR, tone-mapped and future sources. Channel switches requested by HPS take effect only on frame boundaries, so the framebuffer never receives a torn frame. Mid-frame joins are dropped. A per-frame config register (e.g. parallax correction) is latched at frame start. Output is registered, with 1-cycle latency.

Parameters:
NUM_CH, 4, number of input streams (2..16)
SEL_W, 2, select width; 2^SEL_W >= NUM_CH
PIX_W, 24, pixel width per beat (packed RGB 3x8)
CFG_W, 8, width of latched config word
CFG_RST, 10, reset value of cfg_out

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_frame  in  1  config strobe: latch sel_req and cfg_in
sel_req  in  SEL_W  requested channel index
cfg_in  in  CFG_W  config word to latch
cfg_out  out  CFG_W  latched config word
in_data  in  NUM_CH*PIX_W  packed pixels; channel k at [k*PIX_W +: PIX_W]
in_valid  in  NUM_CH  per-channel beat valid
in_sop  in  NUM_CH  per-channel start of frame, qualified by valid
in_eop  in  NUM_CH  per-channel end of frame, qualified by valid
out_data  out  PIX_W  selected pixel
out_valid  out  1  forwarded beat
out_sop  out  1  start of frame
out_eop  out  1  end of frame
active_sel  out  SEL_W  channel currently routed
switch_pending  out  1  pend_sel != active_sel
sel_err  out  1  one-cycle pulse: illegal select request
frame_err  out  1  one-cycle pulse: sop seen inside a frame
frame_cnt  out  16  forwarded frames (optional feature)
last_frame_len  out  24  beats in last complete frame (optional feature)

Behaviour:
- Reset:
  - active_sel = 0, pend_sel = 0, state = WAIT_SOP.
  - cfg_out = CFG_RST.
  - out_data, out_valid, out_sop, out_eop, sel_err, frame_err = 0.
- start_frame = 1:
  - cfg_out <= cfg_in.
  - If sel_req < NUM_CH, pend_sel <= sel_req.
  - Otherwise pend_sel is unchanged and sel_err pulses the next cycle.
- A beat exists on channel c when in_valid[c] = 1. Only beats of active_sel are considered.
- WAIT_SOP state:
  - If switch_pending: active_sel <= pend_sel, and nothing is forwarded this cycle.
  - Else, a beat with sop: forward it and go to IN_FRAME. If eop is also set, it is a single-beat frame: forward it and stay in WAIT_SOP.
  - Else, a beat without sop: drop it (out_valid = 0).
- IN_FRAME state:
  - Forward every beat.
  - A beat with eop: forward it and go to WAIT_SOP.
  - A beat with sop (previous eop missing): forward it with out_sop = 1, pulse frame_err, stay in IN_FRAME.
  - pend_sel changes have no effect until the state returns to WAIT_SOP.
- Forwarding: all outputs update on the clock edge after the input beat (latency 1).
  - Non-forward cycles: out_valid, out_sop, out_eop = 0; out_data holds its last value.
- Simultaneous start_frame and a WAIT_SOP switch: the switch uses the registered pend_sel. The new request is applied on a later cycle.
- Reset mid-frame: the output frame is truncated with no eop. After reset, output resumes on channel 0 at the next sop.

Optional Feature:
VIDEO_MUX_FRAME_STATS_EN:
- Defined:
  - frame_cnt increments on each forwarded eop and wraps from 0xFFFF to 0.
  - A beat counter resets on each forwarded sop and counts forwarded beats, including the sop and eop beats.
  - On a forwarded eop, last_frame_len <= that count; it saturates at 0xFFFFFF.
  - All counters reset to 0.
- Undefined: frame_cnt and last_frame_len are tied to 0. The ports remain so the port list is stable.

Test Plan:
- Reset, then ch0 sends a 4-beat frame with data 0x000001..0x000004 -> out_valid for 4 cycles, 1 cycle delayed; out_sop on 0x000001, out_eop on 0x000004; cfg_out = 10.
- start_frame with sel_req = 2 and cfg_in = 0x33 mid-frame on ch0 -> ch0 frame completes intact. The switch occurs in WAIT_SOP, then active_sel = 2, cfg_out = 0x33, and the next ch2 sop is forwarded.
- Selected channel is already mid-frame after a switch (beats without sop) -> nothing is forwarded until ch2 sop; then the full frame is forwarded.
- start_frame with sel_req = 3 when NUM_CH = 3 -> sel_err is a single 1-cycle pulse, pend_sel is unchanged, routing is unchanged.
- sop on ch0 at beat 3 of an open frame -> frame_err pulses 1 cycle, the beat is forwarded with out_sop = 1, and the state stays IN_FRAME.
- With VIDEO_MUX_FRAME_STATS_EN: 3 frames of lengths 5, 1 and 7 -> frame_cnt = 3 and last_frame_len = 7. A single-beat frame (sop and eop together) is counted as length 1.
